// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the pipeline MEM stage and a DMA/loader requester.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter #(
  parameter int MAX_BURST  = 16,
  parameter int STARVE_LIM = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic [31:0] stat_stall_cycles,
  output logic [31:0] stat_dma_beats
);

  typedef enum logic [1:0] {IDLE, DMA_OWN, YIELD} state_e;

  localparam logic [7:0] MAX_BURST_C  = 8'(MAX_BURST);
  localparam logic [7:0] STARVE_LIM_C = 8'(STARVE_LIM);

  state_e      state_q, state_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic        dma_rvalid_q;
  logic [31:0] dma_rdata_q;

  logic cpu_req;
  logic starve_hit;
  logic dma_sel;
  logic cpu_sel;
  logic stall_raw;

  assign cpu_req    = cpu_mem_read | cpu_mem_write;
  assign starve_hit = dma_req && (starve_cnt_q == STARVE_LIM_C);

  // Ownership depends only on state and requests, so cpu_stall never sees mem_rdata.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    dma_sel    = 1'b0;
    cpu_sel    = 1'b0;
    stall_raw  = 1'b0;
    case (state_q)
      DMA_OWN: begin
        if (dma_req) begin
          dma_sel    = 1'b1;
          stall_raw  = cpu_req;
          beat_cnt_d = beat_cnt_q + 8'd1;
          if ((beat_cnt_q + 8'd1) == MAX_BURST_C) state_d = YIELD;
        end else begin
          cpu_sel    = cpu_req;
          state_d    = IDLE;
          beat_cnt_d = 8'd0;
        end
      end
      YIELD: begin
        cpu_sel    = cpu_req;
        state_d    = IDLE;
        beat_cnt_d = 8'd0;
      end
      default: begin
        // A starved beat is a one-off grant and does not open a burst.
        if (starve_hit) begin
          dma_sel   = 1'b1;
          stall_raw = cpu_req;
        end else if (cpu_req) begin
          cpu_sel = 1'b1;
        end else if (dma_req) begin
          dma_sel    = 1'b1;
          state_d    = DMA_OWN;
          beat_cnt_d = 8'd1;
        end
      end
    endcase
  end

  always_comb begin
    mem_addr  = dma_sel ? dma_addr  : cpu_addr;
    mem_wdata = dma_sel ? dma_wdata : cpu_wdata;
    mem_we    = ~reset & (dma_sel ? dma_we  : (cpu_sel & cpu_mem_write));
    mem_re    = ~reset & (dma_sel ? ~dma_we : (cpu_sel & cpu_mem_read & ~cpu_mem_write));
    dma_gnt   = ~reset & dma_sel;
    cpu_stall = ~reset & stall_raw;
  end

  always_comb begin
    starve_cnt_d = 8'd0;
    if (dma_req && !dma_gnt)
      starve_cnt_d = (starve_cnt_q == STARVE_LIM_C) ? starve_cnt_q : starve_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_cnt_q   <= 8'd0;
      starve_cnt_q <= 8'd0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      dma_rvalid_q <= dma_gnt & ~dma_we;
      if (dma_gnt && !dma_we) dma_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_stall_q, stat_beats_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_q <= 32'd0;
      stat_beats_q <= 32'd0;
    end else begin
      if (cpu_stall) stat_stall_q <= stat_stall_q + 32'd1;
      if (dma_gnt)   stat_beats_q <= stat_beats_q + 32'd1;
    end
  end

  assign stat_stall_cycles = stat_stall_q;
  assign stat_dma_beats    = stat_beats_q;
`else
  assign stat_stall_cycles = 32'd0;
  assign stat_dma_beats    = 32'd0;
`endif

endmodule
